// File: rtl/dot_matrix_pkg.sv
// Shared constants, scan-state encoding and helper functions for the dot-matrix scan controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dot_matrix_pkg;

    localparam int DEF_ROWS  = 8;
    localparam int DEF_COLS  = 8;
    localparam int DEF_LANES = 4;
    localparam int DEF_SEG_W = 2;

    // Widest row count the row-select helper supports.
    localparam int MAX_ROWS = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,     // dark: after reset or while blanked
        ST_SCAN = 1'b1      // rows are being driven
    } scan_state_t;

    // Width of a lane's marker position field.
    function automatic int pw_width(input int cols, input int seg_w);
        return ((cols / seg_w) > 1) ? $clog2(cols / seg_w) : 1;
    endfunction

    // Active-low row select: bit (rows-1-r) low, all others high.
    function automatic logic [MAX_ROWS-1:0] row_sel(input int unsigned r, input int unsigned rows);
        logic [MAX_ROWS-1:0] one;
        one = {{(MAX_ROWS-1){1'b0}}, 1'b1};
        return ~(one << (rows - 1 - r));
    endfunction

endpackage

// File: rtl/dot_matrix_seg_decode.sv
// Maps a marker position to its lit column pattern (SEG_W adjacent columns, position 0 at the MSB end).
// Latency: combinational.
// Backpressure: none.
// Ports: pos - marker position (PW bits); col - column pattern (COLS bits, active high).
module dot_matrix_seg_decode
    import dot_matrix_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int SEG_W = DEF_SEG_W,
    parameter int PW    = pw_width(DEF_COLS, DEF_SEG_W)
) (
    input  logic [PW-1:0]   pos,
    output logic [COLS-1:0] col
);

    localparam logic [COLS-1:0] SEG_MASK = {{SEG_W{1'b1}}, {(COLS-SEG_W){1'b0}}};

    assign col = SEG_MASK >> (int'(pos) * SEG_W);

endmodule

// File: rtl/dot_matrix_scan_ctrl.sv
// Row-scanning driver for a lane-partitioned LED dot matrix with a one-deep placement update slot.
// Latency: outputs registered; a placement accepted in frame N is shown from the start of frame N+1.
// Backpressure: upd_ready low while the pending slot holds an unapplied placement.
// Ports: clk_div/reset (async active-high); blank (sync scan clear); upd_valid/upd_ready/place_in
// (placement handshake, lane 0 in MSB field); blink_mask (bit 0 = lane 0); dot_row (active-low
// row select); dot_column (active-high column data); frame_start (pulse on row 0 entry).
// Optional feature: define DOT_MATRIX_BLINK_EN to enable per-lane blinking every BLINK_FRAMES frames.
module dot_matrix_scan_ctrl
    import dot_matrix_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int LANES        = DEF_LANES,
    parameter int SEG_W        = DEF_SEG_W,
    parameter int DWELL        = 1,
    parameter int BLINK_FRAMES = 16,
    localparam int PW          = pw_width(COLS, SEG_W)
) (
    input  logic                clk_div,
    input  logic                reset,
    input  logic                blank,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [LANES*PW-1:0] place_in,
    input  logic [LANES-1:0]    blink_mask,
    output logic [ROWS-1:0]     dot_row,
    output logic [COLS-1:0]     dot_column,
    output logic                frame_start
);

    localparam int RPL = ROWS / LANES;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW  = (DWELL > 1) ? $clog2(DWELL) : 1;

    scan_state_t         state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [LANES*PW-1:0] pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic [LANES*PW-1:0] active_q, active_d;
    logic [ROWS-1:0]     dot_row_q, dot_row_d;
    logic [COLS-1:0]     dot_column_q, dot_column_d;
    logic                frame_start_q, frame_start_d;

    logic                entry;       // this edge enters row 0
    logic [PW-1:0]       pos_sel;
    logic [COLS-1:0]     col_pat;
    logic                blink_off;

    // Scan state, counters and update handshake
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        dwell_d     = dwell_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        active_d    = active_q;
        entry       = 1'b0;

        if (blank) begin
            state_d = ST_IDLE;
            row_d   = '0;
            dwell_d = '0;
        end else if (state_q == ST_IDLE) begin
            // First unblanked edge starts a fresh frame.
            state_d = ST_SCAN;
            row_d   = '0;
            dwell_d = '0;
            entry   = 1'b1;
        end else if (dwell_q == DW'(DWELL - 1)) begin
            dwell_d = '0;
            if (row_q == RW'(ROWS - 1)) begin
                row_d = '0;
                entry = 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end else begin
            dwell_d = dwell_q + 1'b1;
        end

        // Apply only on frame boundaries so a frame never mixes placements.
        if (entry && pend_full_q) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end
        // Capture needs an empty slot, so it never collides with the apply above;
        // a capture on a row-0 entry edge waits for the following frame.
        if (upd_valid && !pend_full_q) begin
            pend_d      = place_in;
            pend_full_d = 1'b1;
        end
    end

`ifdef DOT_MATRIX_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] frm_cnt_q, frm_cnt_d;   // frames started in the current phase
    logic          phase_q, phase_d;

    always_comb begin
        frm_cnt_d = frm_cnt_q;
        phase_d   = phase_q;
        if (entry) begin
            if (frm_cnt_q == FW'(BLINK_FRAMES)) begin
                frm_cnt_d = FW'(1);
                phase_d   = ~phase_q;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            frm_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
            phase_q   <= phase_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = (^blink_mask) ^ (BLINK_FRAMES > 0);
`endif

    // Select the lane field (and blink enable) for the row about to be driven.
    always_comb begin
        int lane_i;
        lane_i    = 32'(row_d) / RPL;
        pos_sel   = '0;
        blink_off = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_i == l) begin
                pos_sel = active_d[(LANES-1-l)*PW +: PW];
`ifdef DOT_MATRIX_BLINK_EN
                blink_off = phase_d & blink_mask[l];
`endif
            end
        end
    end

    dot_matrix_seg_decode #(
        .COLS  (COLS),
        .SEG_W (SEG_W),
        .PW    (PW)
    ) u_seg_decode (
        .pos (pos_sel),
        .col (col_pat)
    );

    // Row and column registers are computed from the same next-row value so they switch together.
    always_comb begin
        dot_row_d     = '1;
        dot_column_d  = '0;
        frame_start_d = 1'b0;
        if (!blank) begin
            dot_row_d     = ROWS'(row_sel(32'(row_d), ROWS));
            dot_column_d  = blink_off ? '0 : col_pat;
            frame_start_d = entry;
        end
    end

    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            dwell_q       <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            active_q      <= '0;
            dot_row_q     <= '1;
            dot_column_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            dwell_q       <= dwell_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            active_q      <= active_d;
            dot_row_q     <= dot_row_d;
            dot_column_q  <= dot_column_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign upd_ready   = ~pend_full_q;
    assign dot_row     = dot_row_q;
    assign dot_column  = dot_column_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Directed bench for dot_matrix_scan_ctrl: reset, frame content, dwell, handshake, blank, reset mid-frame, blink.
// Latency: n/a.
// Backpressure: n/a.
module tb_dot_matrix_scan_ctrl;

    logic       clk_div = 1'b0;
    logic       reset = 1'b0;
    logic       blank = 1'b0;
    logic       upd_valid = 1'b0;
    logic [7:0] place_in = 8'h00;
    logic [3:0] blink_mask = 4'h0;

    logic       upd_ready, frame_start;
    logic [7:0] dot_row, dot_column;
    logic       upd_ready3, frame_start3;
    logic [7:0] dot_row3, dot_column3;

    int checks = 0;
    int failures = 0;

    localparam logic [7:0] PA = 8'b00_01_10_11;
    localparam logic [7:0] PB = 8'b11_10_01_00;
    localparam logic [7:0] PC = 8'b01_01_01_01;
    localparam logic [7:0] PD = 8'b11_11_11_11;

    dot_matrix_scan_ctrl #(
        .ROWS(8), .COLS(8), .LANES(4), .SEG_W(2), .DWELL(1), .BLINK_FRAMES(2)
    ) u_dut (
        .clk_div(clk_div), .reset(reset), .blank(blank),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .place_in(place_in),
        .blink_mask(blink_mask), .dot_row(dot_row), .dot_column(dot_column),
        .frame_start(frame_start)
    );

    dot_matrix_scan_ctrl #(
        .ROWS(8), .COLS(8), .LANES(4), .SEG_W(2), .DWELL(3), .BLINK_FRAMES(16)
    ) u_dut3 (
        .clk_div(clk_div), .reset(reset), .blank(blank),
        .upd_valid(upd_valid), .upd_ready(upd_ready3), .place_in(place_in),
        .blink_mask(blink_mask), .dot_row(dot_row3), .dot_column(dot_column3),
        .frame_start(frame_start3)
    );

    always #5 clk_div = ~clk_div;

    function automatic logic [7:0] exp_row(input int r);
        case (r)
            0: return 8'b0111_1111;
            1: return 8'b1011_1111;
            2: return 8'b1101_1111;
            3: return 8'b1110_1111;
            4: return 8'b1111_0111;
            5: return 8'b1111_1011;
            6: return 8'b1111_1101;
            default: return 8'b1111_1110;
        endcase
    endfunction

    function automatic logic [7:0] col_of(input logic [7:0] plc, input int r);
        logic [1:0] p;
        p = plc[(3 - r/2)*2 +: 2];
        case (p)
            2'd0: return 8'b1100_0000;
            2'd1: return 8'b0011_0000;
            2'd2: return 8'b0000_1100;
            default: return 8'b0000_0011;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    // Leaves reset low just after an edge; the next edge is the first scan edge.
    task automatic do_reset();
        upd_valid = 1'b0;
        blank     = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        if (dot_row !== 8'hFF) begin failures++; $display("FAIL reset_row got=%b exp=%b", dot_row, 8'hFF); end
        checks++;
        if (dot_column !== 8'h00) begin failures++; $display("FAIL reset_col got=%b exp=%b", dot_column, 8'h00); end
        checks++;
        if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        checks++;
        if (upd_ready !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", upd_ready); end
        checks++;
        tick();
        if (dot_row !== 8'hFF || dot_column !== 8'h00) begin
            failures++; $display("FAIL reset_hold row=%b col=%b exp row=11111111 col=00000000", dot_row, dot_column);
        end
        checks++;
        reset = 1'b0;
    endtask

    task automatic test_frame();
        upd_valid = 1'b1;
        place_in  = PA;
        for (int k = 1; k <= 16; k++) begin
            int r, f;
            logic [7:0] ec;
            tick();
            upd_valid = 1'b0;
            r  = (k - 1) % 8;
            f  = (k - 1) / 8;
            ec = (f == 0) ? 8'b1100_0000 : col_of(PA, r);
            if (dot_row !== exp_row(r)) begin failures++; $display("FAIL frame_row k=%0d got=%b exp=%b", k, dot_row, exp_row(r)); end
            checks++;
            if (dot_column !== ec) begin failures++; $display("FAIL frame_col k=%0d got=%b exp=%b", k, dot_column, ec); end
            checks++;
            if (frame_start !== (r == 0)) begin failures++; $display("FAIL frame_fs k=%0d got=%b exp=%b", k, frame_start, (r == 0)); end
            checks++;
            if (upd_ready !== (k >= 9)) begin failures++; $display("FAIL frame_rdy k=%0d got=%b exp=%b", k, upd_ready, (k >= 9)); end
            checks++;
        end
    endtask

    task automatic test_dwell();
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            int r;
            tick();
            r = ((k - 1) / 3) % 8;
            if (dot_row3 !== exp_row(r)) begin failures++; $display("FAIL dwell_row k=%0d got=%b exp=%b", k, dot_row3, exp_row(r)); end
            checks++;
            if (frame_start3 !== ((k - 1) % 24 == 0)) begin
                failures++; $display("FAIL dwell_fs k=%0d got=%b exp=%b", k, frame_start3, ((k - 1) % 24 == 0));
            end
            checks++;
        end
    endtask

    task automatic test_handshake();
        do_reset();
        upd_valid = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            int r, f;
            logic [7:0] ec;
            place_in = (k == 1) ? PB : (k == 10) ? PC : 8'(k * 37);
            tick();
            r = (k - 1) % 8;
            f = (k - 1) / 8;
            ec = (f == 0) ? 8'b1100_0000 : (f == 1) ? col_of(PB, r) : col_of(PC, r);
            if (dot_column !== ec) begin failures++; $display("FAIL hs_col k=%0d got=%b exp=%b", k, dot_column, ec); end
            checks++;
            if (upd_ready !== (k == 9 || k == 17)) begin
                failures++; $display("FAIL hs_rdy k=%0d got=%b exp=%b", k, upd_ready, (k == 9 || k == 17));
            end
            checks++;
        end
        upd_valid = 1'b0;
    endtask

    task automatic test_blank();
        do_reset();
        upd_valid = 1'b1;
        place_in  = PA;
        tick();
        upd_valid = 1'b0;
        for (int k = 2; k <= 14; k++) tick();
        if (dot_row !== exp_row(5) || dot_column !== col_of(PA, 5)) begin
            failures++; $display("FAIL blank_pre row=%b col=%b exp row=%b col=%b", dot_row, dot_column, exp_row(5), col_of(PA, 5));
        end
        checks++;
        blank = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dot_row !== 8'hFF || dot_column !== 8'h00 || frame_start !== 1'b0) begin
                failures++; $display("FAIL blank_dark i=%0d row=%b col=%b fs=%b exp 11111111/00000000/0", i, dot_row, dot_column, frame_start);
            end
            checks++;
        end
        blank = 1'b0;
        for (int r = 0; r < 8; r++) begin
            tick();
            if (dot_row !== exp_row(r) || dot_column !== col_of(PA, r) || frame_start !== (r == 0)) begin
                failures++; $display("FAIL blank_rel r=%0d row=%b col=%b fs=%b exp %b/%b/%b", r, dot_row, dot_column, frame_start, exp_row(r), col_of(PA, r), (r == 0));
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 3; k++) tick();
        upd_valid = 1'b1;
        place_in  = PD;
        tick();
        upd_valid = 1'b0;
        if (dot_row !== exp_row(3) || upd_ready !== 1'b0) begin
            failures++; $display("FAIL rmid_pre row=%b rdy=%b exp %b/0", dot_row, upd_ready, exp_row(3));
        end
        checks++;
        #3;
        reset = 1'b1;
        #1;
        if (dot_row !== 8'hFF || dot_column !== 8'h00 || frame_start !== 1'b0 || upd_ready !== 1'b1) begin
            failures++; $display("FAIL rmid_idle row=%b col=%b fs=%b rdy=%b exp 11111111/00000000/0/1", dot_row, dot_column, frame_start, upd_ready);
        end
        checks++;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            int r;
            tick();
            r = (k - 1) % 8;
            if (dot_row !== exp_row(r) || dot_column !== 8'b1100_0000 || frame_start !== (r == 0)) begin
                failures++; $display("FAIL rmid_after k=%0d row=%b col=%b fs=%b exp %b/11000000/%b", k, dot_row, dot_column, frame_start, exp_row(r), (r == 0));
            end
            checks++;
        end
    endtask

    task automatic test_blink();
`ifdef DOT_MATRIX_BLINK_EN
        blink_mask = 4'b0010;
        do_reset();
        for (int k = 1; k <= 64; k++) begin
            int r, f;
            logic [7:0] ec;
            tick();
            r  = (k - 1) % 8;
            f  = (k - 1) / 8;
            ec = ((r / 2) == 1 && (f % 4) >= 2) ? 8'h00 : 8'b1100_0000;
            if (dot_column !== ec || dot_row !== exp_row(r)) begin
                failures++; $display("FAIL blink k=%0d row=%b col=%b exp %b/%b", k, dot_row, dot_column, exp_row(r), ec);
            end
            checks++;
        end
`else
        blink_mask = 4'hF;
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            int r;
            tick();
            r = (k - 1) % 8;
            if (dot_column !== 8'b1100_0000 || dot_row !== exp_row(r)) begin
                failures++; $display("FAIL noblink k=%0d row=%b col=%b exp %b/11000000", k, dot_row, dot_column, exp_row(r));
            end
            checks++;
        end
`endif
        blink_mask = 4'h0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_dwell();
        test_handshake();
        test_blank();
        test_reset_mid();
        test_blink();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
